// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage MIPS core.
// Contents: opcode constants, the 11-bit control bundle width with its named
// bit indices, the ALUOp encodings and a small helper that reads the MemRead bit.
package core_pkg;

  localparam int OP_W = 6;
  localparam logic [OP_W-1:0] OP_R_FORMAT = 6'd0;
  localparam logic [OP_W-1:0] OP_J        = 6'd2;
  localparam logic [OP_W-1:0] OP_BEQ      = 6'd4;
  localparam logic [OP_W-1:0] OP_ADDIU    = 6'd9;
  localparam logic [OP_W-1:0] OP_MADDU    = 6'd28;
  localparam logic [OP_W-1:0] OP_LW       = 6'd35;
  localparam logic [OP_W-1:0] OP_SW       = 6'd43;

  // Control bundle, MSB first:
  // {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp[1:0], ExtendSel}
  localparam int CTRL_W     = 11;
  localparam int C_REGDST   = 10;
  localparam int C_ALUSRC   = 9;
  localparam int C_MEMTOREG = 8;
  localparam int C_REGWRITE = 7;
  localparam int C_MEMREAD  = 6;
  localparam int C_MEMWRITE = 5;
  localparam int C_BRANCH   = 4;
  localparam int C_JUMP     = 3;
  localparam int C_ALUOP_HI = 2;
  localparam int C_ALUOP_LO = 1;
  localparam int C_EXTSEL   = 0;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  // An all-zero bundle has no side effects and cannot trigger a hazard.
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] c);
    return c[C_MEMREAD];
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle.
// master: upstream side (drives ID fields, en_reg, flush; observes EX fields and stall).
// slave : the ID/EX register (consumes ID fields, drives EX fields and stall).
interface id_ex_if
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) ();

  logic              en_reg;
  logic              flush;
  logic [CTRL_W-1:0] id_ctrl;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm, id_pc4;

  logic [CTRL_W-1:0] ex_ctrl;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic              ex_valid;
  logic              stall;

  modport master (
    output en_reg, flush, id_ctrl, id_rs, id_rt, id_rd,
           id_rdata1, id_rdata2, id_imm, id_pc4,
    input  ex_ctrl, ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2,
           ex_imm, ex_pc4, ex_valid, stall
  );

  modport slave (
    input  en_reg, flush, id_ctrl, id_rs, id_rt, id_rd,
           id_rdata1, id_rdata2, id_imm, id_pc4,
    output ex_ctrl, ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2,
           ex_imm, ex_pc4, ex_valid, stall
  );

endinterface

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detection (purely combinational).
// Ports: ex_valid_i, ex_mem_read_i, ex_rt_i (instruction in EX), id_rs_i, id_rt_i
// (instruction in ID), en_reg_i (global enable); stall_o holds PC and IF/ID.
// Both ID sources are compared regardless of opcode; this is deliberately conservative.
module hazard_detect_unit #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              en_reg_i,
  output logic              stall_o
);

  always_comb begin
    stall_o = en_reg_i & ex_valid_i & ex_mem_read_i & (ex_rt_i != '0) &
              ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush squash.
// Ports: clk, rst (async active-low), bus (id_ex_if.slave: ID fields in, EX fields,
// ex_valid and stall out). Priority per edge: en_reg low holds, flush loads a bubble,
// stall loads a bubble, otherwise the ID instruction is captured.
// Optional macro ID_EX_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
`ifdef ID_EX_PERF_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  id_ex_if.slave     bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic [DATA_W-1:0] imm_q, imm_d, pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic              stall;

  hazard_detect_unit #(.REG_AW(REG_AW)) u_hdu (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_mem_read(ctrl_q)),
    .ex_rt_i       (rt_q),
    .id_rs_i       (bus.id_rs),
    .id_rt_i       (bus.id_rt),
    .en_reg_i      (bus.en_reg),
    .stall_o       (stall)
  );

  always_comb begin
    ctrl_d   = ctrl_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    if (bus.en_reg) begin
      if (bus.flush || stall) begin
        // Bubble: every field zeroed so nothing stale leaks into EX.
        ctrl_d   = CTRL_BUBBLE;
        rs_d     = '0;
        rt_d     = '0;
        rd_d     = '0;
        rdata1_d = '0;
        rdata2_d = '0;
        imm_d    = '0;
        pc4_d    = '0;
        valid_d  = 1'b0;
      end else begin
        ctrl_d   = bus.id_ctrl;
        rs_d     = bus.id_rs;
        rt_d     = bus.id_rt;
        rd_d     = bus.id_rd;
        rdata1_d = bus.id_rdata1;
        rdata2_d = bus.id_rdata2;
        imm_d    = bus.id_imm;
        pc4_d    = bus.id_pc4;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q   <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.ex_ctrl   = ctrl_q;
  assign bus.ex_rs     = rs_q;
  assign bus.ex_rt     = rt_q;
  assign bus.ex_rd     = rd_q;
  assign bus.ex_rdata1 = rdata1_q;
  assign bus.ex_rdata2 = rdata2_q;
  assign bus.ex_imm    = imm_q;
  assign bus.ex_pc4    = pc4_q;
  assign bus.ex_valid  = valid_q;
  assign bus.stall     = stall;

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // A stall shadowed by a flush is counted as a flush only.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.en_reg) begin
      if (bus.flush) begin
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
      end else if (stall) begin
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import core_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef ID_EX_PERF_CNT_EN
  localparam int CNT_W = 4;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  int exp_sc, exp_fc;
`endif

  // Control bundles {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUOp,Ext}
  localparam logic [10:0] K_LW    = 11'b01111000001;
  localparam logic [10:0] K_ADDIU = 11'b01010000001;
  localparam logic [10:0] K_R     = 11'b10010000100;
  localparam logic [10:0] K_SW    = 11'b01000100001;
  localparam logic [10:0] K_BEQ   = 11'b00000010011;

  typedef struct {
    logic          en;
    logic          flush;
    logic [10:0]   ctrl;
    logic [AW-1:0] rs, rt, rd;
    logic [DW-1:0] r1, r2, imm, pc4;
    logic          exp_stall;
    logic          exp_valid;
  } vec_t;

  typedef struct packed {
    logic [10:0]   ctrl;
    logic [AW-1:0] rs, rt, rd;
    logic [DW-1:0] r1, r2, imm, pc4;
    logic          valid;
  } ex_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  vec_t tbl[$];
  ex_t  sb[$];
  ex_t  last_exp;

  id_ex_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

  id_ex_stage #(
    .DATA_W(DW), .REG_AW(AW)
`ifdef ID_EX_PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic fl, input logic [10:0] c,
                              input int rs, input int rt, input int rd,
                              input logic s, input logic v);
    vec_t x;
    x.en = en; x.flush = fl; x.ctrl = c;
    x.rs = AW'(rs); x.rt = AW'(rt); x.rd = AW'(rd);
    x.r1 = $urandom; x.r2 = $urandom; x.imm = $urandom; x.pc4 = $urandom;
    x.exp_stall = s; x.exp_valid = v;
    return x;
  endfunction

  task automatic drive(input vec_t v);
    bus.en_reg = v.en; bus.flush = v.flush; bus.id_ctrl = v.ctrl;
    bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_rd = v.rd;
    bus.id_rdata1 = v.r1; bus.id_rdata2 = v.r2; bus.id_imm = v.imm; bus.id_pc4 = v.pc4;
  endtask

  task automatic cmp_ex(input string tag, input ex_t e);
    chk({tag, ".valid"}, 32'(bus.ex_valid), 32'(e.valid));
    chk({tag, ".ctrl"},  32'(bus.ex_ctrl),  32'(e.ctrl));
    chk({tag, ".rs"},    32'(bus.ex_rs),    32'(e.rs));
    chk({tag, ".rt"},    32'(bus.ex_rt),    32'(e.rt));
    chk({tag, ".rd"},    32'(bus.ex_rd),    32'(e.rd));
    chk({tag, ".rdata1"}, bus.ex_rdata1, e.r1);
    chk({tag, ".rdata2"}, bus.ex_rdata2, e.r2);
    chk({tag, ".imm"},    bus.ex_imm,    e.imm);
    chk({tag, ".pc4"},    bus.ex_pc4,    e.pc4);
  endtask

  task automatic apply(input vec_t v, input string tag);
    ex_t e, got;
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, ".stall"}, 32'(bus.stall), 32'(v.exp_stall));
    if (!v.en) e = last_exp;
    else if (v.exp_valid)
      e = '{ctrl: v.ctrl, rs: v.rs, rt: v.rt, rd: v.rd, r1: v.r1, r2: v.r2,
            imm: v.imm, pc4: v.pc4, valid: 1'b1};
    else e = '0;
    sb.push_back(e);
`ifdef ID_EX_PERF_CNT_EN
    if (v.en) begin
      if (v.flush) begin if (exp_fc < 15) exp_fc++; end
      else if (v.exp_stall) begin if (exp_sc < 15) exp_sc++; end
    end
`endif
    @(posedge clk);
    #1;
    got = sb.pop_front();
    cmp_ex(tag, got);
    last_exp = got;
`ifdef ID_EX_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_sc));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(exp_fc));
`endif
  endtask

  initial begin
    vec_t v;
    last_exp = '0;
`ifdef ID_EX_PERF_CNT_EN
    exp_sc = 0; exp_fc = 0;
`endif
    // Reset held with random ID traffic.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v = mk(1'b1, 1'($urandom), 11'($urandom), int'($urandom_range(31)),
             int'($urandom_range(31)), int'($urandom_range(31)), 1'b0, 1'b0);
      drive(v);
      @(posedge clk);
      #1;
      cmp_ex($sformatf("reset%0d", i), '0);
      chk("reset.stall", 32'(bus.stall), 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;

    // row | meaning
    tbl.push_back(mk(1,0,K_ADDIU, 1, 2, 0, 0,1)); // first after reset
    tbl.push_back(mk(1,0,K_LW,    1, 8, 0, 0,1));
    tbl.push_back(mk(1,0,K_R,     8, 9,10, 1,0)); // load-use on rs
    tbl.push_back(mk(1,0,K_R,     8, 9,10, 0,1)); // re-presented, captured
    tbl.push_back(mk(1,0,K_LW,    2, 0, 0, 0,1));
    tbl.push_back(mk(1,0,K_R,     0, 5, 6, 0,1)); // $zero never hazards
    tbl.push_back(mk(1,0,K_LW,    4, 3, 0, 0,1));
    tbl.push_back(mk(1,1,K_ADDIU, 3, 4, 0, 1,0)); // flush beats stall
    tbl.push_back(mk(1,0,K_ADDIU, 3, 4, 0, 0,1));
    tbl.push_back(mk(1,0,K_LW,    5, 6, 0, 0,1));
    tbl.push_back(mk(1,0,K_SW,    7, 6, 0, 1,0)); // load-use on rt
    tbl.push_back(mk(1,0,K_SW,    7, 6, 0, 0,1));
    tbl.push_back(mk(1,0,K_LW,    1,11, 0, 0,1));
    tbl.push_back(mk(0,0,K_R,    11, 1,12, 0,1)); // freeze x3, stall forced low
    tbl.push_back(mk(0,0,K_R,    11, 1,12, 0,1));
    tbl.push_back(mk(0,0,K_R,    11, 1,12, 0,1));
    tbl.push_back(mk(1,0,K_R,    11, 1,12, 1,0)); // resumes: stall now
    tbl.push_back(mk(1,0,K_R,    11, 1,12, 0,1));
    tbl.push_back(mk(1,1,K_BEQ,  11, 2, 0, 0,0)); // plain flush
    tbl.push_back(mk(0,1,K_BEQ,  11, 2, 0, 0,0)); // flush ignored while frozen
    tbl.push_back(mk(1,0,K_LW,    0,13, 0, 0,1));
    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // Reset while a stall is asserted.
    apply(mk(1,0,K_LW, 1,12, 0, 0,1), "pre_rst_lw");
    @(negedge clk);
    drive(mk(1,0,K_R, 12, 3, 4, 1,0));
    #1;
    chk("midstall.stall_before", 32'(bus.stall), 32'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("midstall.stall_after", 32'(bus.stall), 32'h0);
    cmp_ex("midstall", '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    last_exp = '0;
`ifdef ID_EX_PERF_CNT_EN
    exp_sc = 0; exp_fc = 0;
    chk("midstall.stall_cnt", 32'(stall_cnt), 32'h0);
    // 20 back-to-back load-use pairs saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      apply(mk(1,0,K_LW, 1, 8, 0, 0,1), $sformatf("sat_lw%0d", i));
      apply(mk(1,0,K_R,  8, 9, 1, 1,0), $sformatf("sat_st%0d", i));
      apply(mk(1,0,K_R,  8, 9, 1, 0,1), $sformatf("sat_r%0d", i));
    end
    chk("sat.final", 32'(stall_cnt), 32'd15);
`else
    apply(mk(1,0,K_ADDIU, 1, 2, 0, 0,1), "post_rst_addiu");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
